calc_rs_scheduler: RTL and testbench
====================================

// Module: calc_rs_scheduler
// PURPOSE
//  Reservation station and dispatch scheduler for the integer calculation unit (LUI..SRAI class).
//  Buffers issued calc instructions, wakes operands from the two CDBs, selects one ready entry
//  per cycle with rotating priority and drives a registered dispatch to the ALU.
//  Sits between the issue stage and the ALU; the ROB owns tags and flush.
// PARAMETERS
//  RS_DEPTH   8   entries; power of two, >=2
//  RS_IDX_W   3   log2(RS_DEPTH)
//  ROB_W      4   ROB tag width
// PORTS
//  clk_in          in   1   clock; all state on rising edge
//  rst_n_in        in   1   asynchronous, active-low reset
//  rdy_in          in   1   global ready; low = freeze all state, no accept, no dispatch
//  clear_in        in   1   mispredict flush from ROB
//  iss_valid_in    in   1   issue request
//  iss_ready_out   out  1   >=1 free entry (combinational from busy bits)
//  iss_type_in     in   `INST_TYPE_WIDTH  decoded instruction type
//  iss_vj_in/iss_vk_in  in  32  operand values (valid when matching q*_busy low)
//  iss_qj_in/iss_qk_in  in  ROB_W  producer tags
//  iss_qj_busy_in/iss_qk_busy_in in 1  operand still pending
//  iss_imm_in, iss_pc_in  in  32  immediate, PC
//  iss_dest_in     in   ROB_W  destination ROB tag
//  cdb0_valid_in, cdb1_valid_in  in 1;  cdb0_tag_in, cdb1_tag_in in ROB_W;  cdb0_val_in, cdb1_val_in in 32
//  alu_valid_out   out  1   dispatch strobe (registered)
//  alu_type_out    out  `INST_TYPE_WIDTH;  alu_a_out, alu_b_out, alu_imm_out, alu_pc_out  out 32
//  alu_dest_out    out  ROB_W
//  illegal_out     out  1   one-cycle pulse: non-calc type presented on issue
// BEHAVIOUR
//  Reset (rst_n_in=0, async): all busy=0, grant pointer=0, every output register 0.
//  Accept: iss_valid_in & iss_ready_out & rdy_in & !clear_in & calc type -> write lowest-index free entry.
//  Non-calc type with iss_valid_in: no allocation; illegal_out=1 next cycle.
//  Same-cycle wakeup: if issuing operand's tag matches a valid CDB this cycle, store CDB value, busy=0.
//  Wakeup: every busy entry compares qj/qk against both CDBs each cycle; match -> capture value, clear pending.
//  Both CDBs same tag: cdb0 wins (values are identical by ROB contract).
//  Ready = busy & !qj_pending & !qk_pending, evaluated on registered state (wake at t -> eligible t+1).
//  Select: first ready entry scanning from grant pointer upward with wrap; pointer <= winner+1 (mod RS_DEPTH).
//  Dispatch: winner's fields registered to alu_*_out, alu_valid_out=1 for exactly one cycle; entry freed same edge.
//  No ready entry -> alu_valid_out=0, other alu_* outputs hold last value.
//  Latency: issue at edge t with operands ready -> alu_valid_out high after edge t+1 (min 2 cycles to ALU).
//  Freed slot visible to iss_ready_out in the following cycle (no same-cycle reuse).
//  Full: all busy -> iss_ready_out=0; request ignored, nothing dropped silently at issue (issue stage holds).
//  clear_in=1: all busy<=0, no accept, alu_valid_out<=0, illegal_out<=0; grant pointer unchanged.
//  clear_in overrides rdy_in; rdy_in=0 otherwise freezes everything incl. outputs (CDB inputs ignored).
//  Reset mid-dispatch: outputs drop to 0 immediately (async), entries discarded.
// STRUCTURE
//  Shared `include info.v: `INST_TYPE_WIDTH, instruction type codes, `TRUE/`FALSE, ROB tag width.
//  Calc-class test reuses the existing type-classification function module (one instance on issue type).
//  Sub-module rr_pick (RS_DEPTH req vector + pointer -> grant idx, any): rotating-priority picker.
//  Entry array, wakeup compare, and dispatch register stay in this module.
// TESTING
//  Reset: assert rst_n_in=0 mid-run -> alu_valid_out=0, iss_ready_out=1, all entries empty.
//  Ready issue: ADDI, qj/qk clear, vj=5, imm=3, dest=2 -> alu_valid_out=1 two edges later, a=5, imm=3, dest=2.
//  Wakeup: ADD qj=7 pending; cdb1 tag 7 val 0x10 at t -> dispatch after t+1 with alu_a_out=0x10.
//  Bypass: issue qk=4 pending while cdb0 tag 4 val 9 same cycle -> stored as 9, dispatched next cycle.
//  Fairness/full: fill 8 entries all ready -> iss_ready_out=0; dispatches in order 0..7, one per cycle.
//  Flush/illegal: clear_in with 3 busy -> empty next cycle, no dispatch; issue LW type -> illegal_out pulse, no allocate.

Source files
------------

// File: rtl/calc_rs_scheduler_pkg.sv
// Shared constants, instruction type codes, entry layout and helper
// functions for the calc-class reservation station.
package calc_rs_scheduler_pkg;

    localparam int RS_DEPTH        = 8;
    localparam int RS_IDX_W        = 3;
    localparam int ROB_W           = 4;
    localparam int INST_TYPE_WIDTH = 6;
    localparam int DATA_W          = 32;

    localparam logic [RS_IDX_W-1:0] IDX_ONE = {{(RS_IDX_W-1){1'b0}}, 1'b1};

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Decoded instruction type codes
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_NOP   = 6'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_LUI   = 6'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_AUIPC = 6'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_JAL   = 6'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_JALR  = 6'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_BEQ   = 6'd5;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_BNE   = 6'd6;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_BLT   = 6'd7;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_BGE   = 6'd8;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_BLTU  = 6'd9;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_BGEU  = 6'd10;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_LB    = 6'd11;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_LH    = 6'd12;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_LW    = 6'd13;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_LBU   = 6'd14;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_LHU   = 6'd15;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SB    = 6'd16;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SH    = 6'd17;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SW    = 6'd18;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_ADDI  = 6'd19;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SLTI  = 6'd20;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SLTIU = 6'd21;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_XORI  = 6'd22;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_ORI   = 6'd23;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_ANDI  = 6'd24;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SLLI  = 6'd25;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SRLI  = 6'd26;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SRAI  = 6'd27;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_ADD   = 6'd28;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SUB   = 6'd29;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SLL   = 6'd30;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SLT   = 6'd31;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SLTU  = 6'd32;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_XOR   = 6'd33;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SRL   = 6'd34;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_SRA   = 6'd35;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_OR    = 6'd36;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_AND   = 6'd37;

    // One reservation-station slot (busy bit is kept outside)
    typedef struct packed {
        logic [INST_TYPE_WIDTH-1:0] typ;
        logic [DATA_W-1:0]          vj;
        logic [DATA_W-1:0]          vk;
        logic [DATA_W-1:0]          imm;
        logic [DATA_W-1:0]          pc;
        logic [ROB_W-1:0]           qj;
        logic [ROB_W-1:0]           qk;
        logic [ROB_W-1:0]           dest;
        logic                       qj_pend;
        logic                       qk_pend;
    } rs_entry_t;

    // Operand state after a CDB snoop
    typedef struct packed {
        logic              pend;
        logic [DATA_W-1:0] val;
    } operand_t;

    // True for the integer calculation class handled by this station
    function automatic logic is_calc_type(input logic [INST_TYPE_WIDTH-1:0] t);
        logic calc;
        case (t)
            TYPE_LUI, TYPE_AUIPC,
            TYPE_ADDI, TYPE_SLTI, TYPE_SLTIU, TYPE_XORI, TYPE_ORI,
            TYPE_ANDI, TYPE_SLLI, TYPE_SRLI, TYPE_SRAI,
            TYPE_ADD, TYPE_SUB, TYPE_SLL, TYPE_SLT, TYPE_SLTU,
            TYPE_XOR, TYPE_SRL, TYPE_SRA, TYPE_OR, TYPE_AND: calc = TRUE;
            default:                                         calc = FALSE;
        endcase
        return calc;
    endfunction

    // Snoop both CDBs for a pending operand; cdb0 has precedence on a tie
    function automatic operand_t wake_operand(
        input logic              pend,
        input logic [ROB_W-1:0]  q,
        input logic [DATA_W-1:0] v,
        input logic              c0_valid,
        input logic [ROB_W-1:0]  c0_tag,
        input logic [DATA_W-1:0] c0_val,
        input logic              c1_valid,
        input logic [ROB_W-1:0]  c1_tag,
        input logic [DATA_W-1:0] c1_val
    );
        operand_t r;
        if (pend && c0_valid && (c0_tag == q)) begin
            r = '{pend: 1'b0, val: c0_val};
        end else if (pend && c1_valid && (c1_tag == q)) begin
            r = '{pend: 1'b0, val: c1_val};
        end else begin
            r = '{pend: pend, val: v};
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_rs_scheduler_if.sv
// Issue, CDB and ALU-dispatch bundle of the calc reservation station.
// slave = the scheduler, master = issue stage / CDB / ALU side.
interface calc_rs_scheduler_if;
    import calc_rs_scheduler_pkg::*;

    logic                       iss_valid_in;
    logic                       iss_ready_out;
    logic [INST_TYPE_WIDTH-1:0] iss_type_in;
    logic [DATA_W-1:0]          iss_vj_in;
    logic [DATA_W-1:0]          iss_vk_in;
    logic [ROB_W-1:0]           iss_qj_in;
    logic [ROB_W-1:0]           iss_qk_in;
    logic                       iss_qj_busy_in;
    logic                       iss_qk_busy_in;
    logic [DATA_W-1:0]          iss_imm_in;
    logic [DATA_W-1:0]          iss_pc_in;
    logic [ROB_W-1:0]           iss_dest_in;

    logic                       cdb0_valid_in;
    logic [ROB_W-1:0]           cdb0_tag_in;
    logic [DATA_W-1:0]          cdb0_val_in;
    logic                       cdb1_valid_in;
    logic [ROB_W-1:0]           cdb1_tag_in;
    logic [DATA_W-1:0]          cdb1_val_in;

    logic                       alu_valid_out;
    logic [INST_TYPE_WIDTH-1:0] alu_type_out;
    logic [DATA_W-1:0]          alu_a_out;
    logic [DATA_W-1:0]          alu_b_out;
    logic [DATA_W-1:0]          alu_imm_out;
    logic [DATA_W-1:0]          alu_pc_out;
    logic [ROB_W-1:0]           alu_dest_out;
    logic                       illegal_out;

    modport slave (
        input  iss_valid_in, iss_type_in, iss_vj_in, iss_vk_in, iss_qj_in, iss_qk_in,
               iss_qj_busy_in, iss_qk_busy_in, iss_imm_in, iss_pc_in, iss_dest_in,
               cdb0_valid_in, cdb0_tag_in, cdb0_val_in,
               cdb1_valid_in, cdb1_tag_in, cdb1_val_in,
        output iss_ready_out, alu_valid_out, alu_type_out, alu_a_out, alu_b_out,
               alu_imm_out, alu_pc_out, alu_dest_out, illegal_out
    );

    modport master (
        output iss_valid_in, iss_type_in, iss_vj_in, iss_vk_in, iss_qj_in, iss_qk_in,
               iss_qj_busy_in, iss_qk_busy_in, iss_imm_in, iss_pc_in, iss_dest_in,
               cdb0_valid_in, cdb0_tag_in, cdb0_val_in,
               cdb1_valid_in, cdb1_tag_in, cdb1_val_in,
        input  iss_ready_out, alu_valid_out, alu_type_out, alu_a_out, alu_b_out,
               alu_imm_out, alu_pc_out, alu_dest_out, illegal_out
    );

endinterface

// File: rtl/calc_rs_scheduler_rr_pick.sv
// Rotating-priority picker: returns the first requester at or above ptr,
// wrapping around, plus a flag telling whether any request was present.
module calc_rs_scheduler_rr_pick
    import calc_rs_scheduler_pkg::*;
#(
    parameter int N = RS_DEPTH,
    parameter int W = RS_IDX_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant_idx,
    output logic         any_grant
);

    logic [W-1:0] cand_s;

    // Walk offsets from farthest to nearest so the requester nearest ptr is kept last
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        cand_s    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand_s    = ptr + W'(k);
            grant_idx = req[cand_s] ? cand_s : grant_idx;
            any_grant = any_grant | req[cand_s];
        end
    end

endmodule

// File: rtl/calc_rs_scheduler.sv
// Calc-class reservation station: buffers issued instructions, wakes their
// operands from two CDBs, picks one ready entry per cycle with rotating
// priority and presents it on a registered ALU dispatch port.
module calc_rs_scheduler
    import calc_rs_scheduler_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    input  logic               clear_in,
    calc_rs_scheduler_if.slave bus
);

    logic [RS_DEPTH-1:0] busy_r;
    logic [RS_DEPTH-1:0] busy_nxt_s;
    logic [RS_DEPTH-1:0] ready_s;
    rs_entry_t           ent_r     [RS_DEPTH];
    rs_entry_t           ent_nxt_s [RS_DEPTH];
    rs_entry_t           new_entry_s;
    operand_t            wake_j_s  [RS_DEPTH];
    operand_t            wake_k_s  [RS_DEPTH];
    operand_t            iss_j_s;
    operand_t            iss_k_s;

    logic [RS_IDX_W-1:0] ptr_r;
    logic [RS_IDX_W-1:0] grant_idx_s;
    logic [RS_IDX_W-1:0] free_idx_s;
    logic                pick_any_s;
    logic                free_any_s;
    logic                is_calc_s;
    logic                accept_s;

    logic                       alu_valid_r;
    logic [INST_TYPE_WIDTH-1:0] alu_type_r;
    logic [DATA_W-1:0]          alu_a_r;
    logic [DATA_W-1:0]          alu_b_r;
    logic [DATA_W-1:0]          alu_imm_r;
    logic [DATA_W-1:0]          alu_pc_r;
    logic [ROB_W-1:0]           alu_dest_r;
    logic                       illegal_r;

    assign is_calc_s         = is_calc_type(bus.iss_type_in);
    assign free_any_s        = ~(&busy_r);
    assign accept_s          = bus.iss_valid_in & free_any_s & is_calc_s;
    assign bus.iss_ready_out = free_any_s;

    // CDB snoop of every stored entry and the ready vector from registered state
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            wake_j_s[i] = wake_operand(ent_r[i].qj_pend, ent_r[i].qj, ent_r[i].vj,
                                       bus.cdb0_valid_in, bus.cdb0_tag_in, bus.cdb0_val_in,
                                       bus.cdb1_valid_in, bus.cdb1_tag_in, bus.cdb1_val_in);
            wake_k_s[i] = wake_operand(ent_r[i].qk_pend, ent_r[i].qk, ent_r[i].vk,
                                       bus.cdb0_valid_in, bus.cdb0_tag_in, bus.cdb0_val_in,
                                       bus.cdb1_valid_in, bus.cdb1_tag_in, bus.cdb1_val_in);
            ready_s[i]  = busy_r[i] & ~ent_r[i].qj_pend & ~ent_r[i].qk_pend;
        end
    end

    // Build the incoming entry, catching a CDB result broadcast in the issue cycle
    always_comb begin
        iss_j_s = wake_operand(bus.iss_qj_busy_in, bus.iss_qj_in, bus.iss_vj_in,
                               bus.cdb0_valid_in, bus.cdb0_tag_in, bus.cdb0_val_in,
                               bus.cdb1_valid_in, bus.cdb1_tag_in, bus.cdb1_val_in);
        iss_k_s = wake_operand(bus.iss_qk_busy_in, bus.iss_qk_in, bus.iss_vk_in,
                               bus.cdb0_valid_in, bus.cdb0_tag_in, bus.cdb0_val_in,
                               bus.cdb1_valid_in, bus.cdb1_tag_in, bus.cdb1_val_in);
        new_entry_s         = '0;
        new_entry_s.typ     = bus.iss_type_in;
        new_entry_s.vj      = iss_j_s.val;
        new_entry_s.vk      = iss_k_s.val;
        new_entry_s.imm     = bus.iss_imm_in;
        new_entry_s.pc      = bus.iss_pc_in;
        new_entry_s.qj      = bus.iss_qj_in;
        new_entry_s.qk      = bus.iss_qk_in;
        new_entry_s.dest    = bus.iss_dest_in;
        new_entry_s.qj_pend = iss_j_s.pend;
        new_entry_s.qk_pend = iss_k_s.pend;
    end

    // Lowest-index free slot, judged on registered busy bits only
    always_comb begin
        free_idx_s = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            free_idx_s = busy_r[i] ? free_idx_s : RS_IDX_W'(i);
        end
    end

    calc_rs_scheduler_rr_pick #(
        .N (RS_DEPTH),
        .W (RS_IDX_W)
    ) u_rr_pick (
        .req       (ready_s),
        .ptr       (ptr_r),
        .grant_idx (grant_idx_s),
        .any_grant (pick_any_s)
    );

    // Next-state of each slot: fresh issue, operand wakeup, or hold; dispatch frees the winner
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_nxt_s[i] = ent_r[i];
            if (accept_s && (free_idx_s == RS_IDX_W'(i))) begin
                ent_nxt_s[i] = new_entry_s;
            end else if (busy_r[i]) begin
                ent_nxt_s[i].qj_pend = wake_j_s[i].pend;
                ent_nxt_s[i].vj      = wake_j_s[i].val;
                ent_nxt_s[i].qk_pend = wake_k_s[i].pend;
                ent_nxt_s[i].vk      = wake_k_s[i].val;
            end else begin
                ent_nxt_s[i] = ent_r[i];
            end

            busy_nxt_s[i] = busy_r[i];
            if (accept_s && (free_idx_s == RS_IDX_W'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (pick_any_s && (grant_idx_s == RS_IDX_W'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Entry array, grant pointer and dispatch/illegal registers; flush beats the freeze
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_r      <= '0;
            ptr_r       <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_r[i] <= '0;
            end
            alu_valid_r <= 1'b0;
            alu_type_r  <= '0;
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            alu_imm_r   <= '0;
            alu_pc_r    <= '0;
            alu_dest_r  <= '0;
            illegal_r   <= 1'b0;
        end else if (clear_in) begin
            busy_r      <= '0;
            alu_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (rdy_in) begin
            busy_r <= busy_nxt_s;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_r[i] <= ent_nxt_s[i];
            end
            illegal_r <= bus.iss_valid_in & ~is_calc_s;
            if (pick_any_s) begin
                alu_valid_r <= 1'b1;
                alu_type_r  <= ent_r[grant_idx_s].typ;
                alu_a_r     <= ent_r[grant_idx_s].vj;
                alu_b_r     <= ent_r[grant_idx_s].vk;
                alu_imm_r   <= ent_r[grant_idx_s].imm;
                alu_pc_r    <= ent_r[grant_idx_s].pc;
                alu_dest_r  <= ent_r[grant_idx_s].dest;
                ptr_r       <= grant_idx_s + IDX_ONE;
            end else begin
                alu_valid_r <= 1'b0;
            end
        end
    end

    assign bus.alu_valid_out = alu_valid_r;
    assign bus.alu_type_out  = alu_type_r;
    assign bus.alu_a_out     = alu_a_r;
    assign bus.alu_b_out     = alu_b_r;
    assign bus.alu_imm_out   = alu_imm_r;
    assign bus.alu_pc_out    = alu_pc_r;
    assign bus.alu_dest_out  = alu_dest_r;
    assign bus.illegal_out   = illegal_r;

endmodule

// File: tb/tb_calc_rs_scheduler.sv
// Self-checking bench for calc_rs_scheduler: vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_calc_rs_scheduler;
    import calc_rs_scheduler_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;
    logic clr;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    calc_rs_scheduler_if bus ();

    calc_rs_scheduler dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .clear_in (clr),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        logic [5:0]  typ;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0]  qj, qk, dest;
        bit          pj, pk;
    } m_ent_t;

    m_ent_t      m_ent [8];
    int          m_ptr;
    logic        m_valid, m_ill;
    logic [5:0]  m_type;
    logic [3:0]  m_dest;
    logic [31:0] m_a, m_b, m_imm, m_pc;

    function automatic bit model_calc(input logic [5:0] t);
        return (t == TYPE_LUI) || (t == TYPE_AUIPC) || ((t >= TYPE_ADDI) && (t <= TYPE_AND));
    endfunction

    function automatic bit model_has_free();
        for (int i = 0; i < 8; i++) if (!m_ent[i].busy) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_ent[i] = '{default: 0};
        m_ptr = 0; m_valid = 0; m_ill = 0; m_type = 0; m_dest = 0;
        m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
    endfunction

    // Capture any pending operand whose producer appears on a CDB (cdb0 first)
    function automatic void model_wake(inout m_ent_t e);
        if (e.pj) begin
            if (bus.cdb0_valid_in && bus.cdb0_tag_in == e.qj) begin e.vj = bus.cdb0_val_in; e.pj = 0; end
            else if (bus.cdb1_valid_in && bus.cdb1_tag_in == e.qj) begin e.vj = bus.cdb1_val_in; e.pj = 0; end
        end
        if (e.pk) begin
            if (bus.cdb0_valid_in && bus.cdb0_tag_in == e.qk) begin e.vk = bus.cdb0_val_in; e.pk = 0; end
            else if (bus.cdb1_valid_in && bus.cdb1_tag_in == e.qk) begin e.vk = bus.cdb1_val_in; e.pk = 0; end
        end
    endfunction

    // Advance the model across one rising edge using the currently driven inputs
    function automatic void model_edge();
        int win;
        int slot;
        m_ent_t e;
        if (clr) begin
            for (int i = 0; i < 8; i++) m_ent[i].busy = 0;
            m_valid = 0; m_ill = 0;
            return;
        end
        if (!rdy) return;
        win = -1; slot = -1;
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (m_ptr + k) % 8;
            if (win < 0 && m_ent[i].busy && !m_ent[i].pj && !m_ent[i].pk) win = i;
        end
        for (int i = 0; i < 8; i++) if (slot < 0 && !m_ent[i].busy) slot = i;
        if (win >= 0) begin
            m_valid = 1; m_type = m_ent[win].typ; m_a = m_ent[win].vj; m_b = m_ent[win].vk;
            m_imm = m_ent[win].imm; m_pc = m_ent[win].pc; m_dest = m_ent[win].dest;
            m_ptr = (win + 1) % 8;
        end else begin
            m_valid = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (m_ent[i].busy) begin e = m_ent[i]; model_wake(e); m_ent[i] = e; end
        end
        if (win >= 0) m_ent[win].busy = 0;
        m_ill = bus.iss_valid_in && !model_calc(bus.iss_type_in);
        if (bus.iss_valid_in && model_calc(bus.iss_type_in) && slot >= 0) begin
            e.busy = 1; e.typ = bus.iss_type_in; e.imm = bus.iss_imm_in; e.pc = bus.iss_pc_in;
            e.dest = bus.iss_dest_in; e.qj = bus.iss_qj_in; e.qk = bus.iss_qk_in;
            e.vj = bus.iss_vj_in; e.vk = bus.iss_vk_in;
            e.pj = bus.iss_qj_busy_in; e.pk = bus.iss_qk_busy_in;
            model_wake(e);
            m_ent[slot] = e;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic compare_outputs();
        check("alu_valid", 160'(bus.alu_valid_out), 160'(m_valid));
        check("illegal", 160'(bus.illegal_out), 160'(m_ill));
        check("alu_payload",
              160'({bus.alu_type_out, bus.alu_dest_out, bus.alu_a_out, bus.alu_b_out, bus.alu_imm_out, bus.alu_pc_out}),
              160'({m_type, m_dest, m_a, m_b, m_imm, m_pc}));
    endtask

    task automatic step();
        check("iss_ready", 160'(bus.iss_ready_out), 160'(model_has_free()));
        model_edge();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic set_idle();
        bus.iss_valid_in  = 1'b0;
        bus.cdb0_valid_in = 1'b0;
        bus.cdb1_valid_in = 1'b0;
    endtask

    task automatic set_issue(input logic [5:0] typ, input logic qjb, input logic [3:0] qj, input logic [31:0] vj,
                             input logic qkb, input logic [3:0] qk, input logic [31:0] vk,
                             input logic [31:0] imm, input logic [3:0] dest);
        bus.iss_valid_in = 1'b1; bus.iss_type_in = typ;
        bus.iss_qj_busy_in = qjb; bus.iss_qj_in = qj; bus.iss_vj_in = vj;
        bus.iss_qk_busy_in = qkb; bus.iss_qk_in = qk; bus.iss_vk_in = vk;
        bus.iss_imm_in = imm; bus.iss_dest_in = dest;
        bus.iss_pc_in = 32'h8000_0000 + {28'd0, dest};
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_valid", 160'(bus.alu_valid_out), 160'(1'b0));
        check("reset_ready", 160'(bus.iss_ready_out), 160'(1'b1));
        compare_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [5:0]  typ;
        logic        qjb;
        logic [31:0] vj, vk, imm;
        logic [3:0]  dest;
        logic        exp_ill;
        logic        exp_disp;
        logic [31:0] exp_a;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; clr = 1'b0;
        bus.iss_valid_in = 0; bus.iss_type_in = 0; bus.iss_vj_in = 0; bus.iss_vk_in = 0;
        bus.iss_qj_in = 0; bus.iss_qk_in = 0; bus.iss_qj_busy_in = 0; bus.iss_qk_busy_in = 0;
        bus.iss_imm_in = 0; bus.iss_pc_in = 0; bus.iss_dest_in = 0;
        bus.cdb0_valid_in = 0; bus.cdb0_tag_in = 0; bus.cdb0_val_in = 0;
        bus.cdb1_valid_in = 0; bus.cdb1_tag_in = 0; bus.cdb1_val_in = 0;

        vecs[0] = '{TYPE_ADDI, 1'b0, 32'd5,   32'd0,  32'd3,          4'd2, 1'b0, 1'b1, 32'd5};
        vecs[1] = '{TYPE_ADD,  1'b0, 32'd100, 32'd23, 32'd0,          4'd5, 1'b0, 1'b1, 32'd100};
        vecs[2] = '{TYPE_LW,   1'b0, 32'd1,   32'd2,  32'd4,          4'd6, 1'b1, 1'b0, 32'd0};
        vecs[3] = '{TYPE_SW,   1'b0, 32'd1,   32'd2,  32'd4,          4'd7, 1'b1, 1'b0, 32'd0};
        vecs[4] = '{TYPE_LUI,  1'b0, 32'd0,   32'd0,  32'h1234_5000,  4'd9, 1'b0, 1'b1, 32'd0};
        vecs[5] = '{TYPE_SUB,  1'b1, 32'd77,  32'd1,  32'd0,          4'd1, 1'b0, 1'b0, 32'd0};
        vecs[6] = '{TYPE_NOP,  1'b0, 32'd3,   32'd3,  32'd0,          4'd3, 1'b1, 1'b0, 32'd0};

        #1;
        apply_reset();

        // Table: single issue from empty, illegal flag after one edge, dispatch after two
        for (int v = 0; v < 7; v++) begin
            set_issue(vecs[v].typ, vecs[v].qjb, 4'd3, vecs[v].vj, 1'b0, 4'd0, vecs[v].vk, vecs[v].imm, vecs[v].dest);
            step();
            check("vec_illegal", 160'(bus.illegal_out), 160'(vecs[v].exp_ill));
            set_idle();
            step();
            check("vec_dispatch", 160'(bus.alu_valid_out), 160'(vecs[v].exp_disp));
            if (vecs[v].exp_disp) begin
                check("vec_a", 160'(bus.alu_a_out), 160'(vecs[v].exp_a));
                check("vec_imm", 160'(bus.alu_imm_out), 160'(vecs[v].imm));
                check("vec_dest", 160'(bus.alu_dest_out), 160'(vecs[v].dest));
            end
            clr = 1'b1; step(); clr = 1'b0;
        end

        // Wakeup via cdb1: capture at t, dispatch visible after t+1
        set_issue(TYPE_ADD, 1'b1, 4'd7, 32'hDEAD, 1'b0, 4'd0, 32'd1, 32'd0, 4'd3);
        step();
        set_idle();
        bus.cdb1_valid_in = 1'b1; bus.cdb1_tag_in = 4'd7; bus.cdb1_val_in = 32'h10;
        step();
        check("wake_no_early", 160'(bus.alu_valid_out), 160'(1'b0));
        set_idle();
        step();
        check("wake_valid", 160'(bus.alu_valid_out), 160'(1'b1));
        check("wake_a", 160'(bus.alu_a_out), 160'(32'h10));

        // Same-cycle bypass on issue through cdb0
        set_issue(TYPE_ADD, 1'b0, 4'd0, 32'd2, 1'b1, 4'd4, 32'hBEEF, 32'd0, 4'd4);
        bus.cdb0_valid_in = 1'b1; bus.cdb0_tag_in = 4'd4; bus.cdb0_val_in = 32'd9;
        step();
        set_idle();
        step();
        check("bypass_valid", 160'(bus.alu_valid_out), 160'(1'b1));
        check("bypass_b", 160'(bus.alu_b_out), 160'(32'd9));

        // Fill all eight, extra request refused, release together, drain in order 0..7
        set_idle();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            set_issue(TYPE_ADDI, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0, 32'(i), 4'(i));
            step();
        end
        check("full_ready", 160'(bus.iss_ready_out), 160'(1'b0));
        set_issue(TYPE_ADDI, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd99, 4'd15);
        step();
        set_idle();
        bus.cdb0_valid_in = 1'b1; bus.cdb0_tag_in = 4'd9; bus.cdb0_val_in = 32'h77;
        step();
        set_idle();
        for (int i = 0; i < 8; i++) begin
            step();
            check("drain_valid", 160'(bus.alu_valid_out), 160'(1'b1));
            check("drain_order", 160'(bus.alu_dest_out), 160'(i));
        end
        step();
        check("drain_done", 160'(bus.alu_valid_out), 160'(1'b0));

        // Flush with three waiting entries; a later broadcast must wake nothing
        for (int i = 0; i < 3; i++) begin
            set_issue(TYPE_OR, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'(i + 10));
            step();
        end
        set_idle();
        clr = 1'b1; step(); clr = 1'b0;
        check("flush_valid", 160'(bus.alu_valid_out), 160'(1'b0));
        bus.cdb0_valid_in = 1'b1; bus.cdb0_tag_in = 4'd12; bus.cdb0_val_in = 32'd5;
        step();
        set_idle();
        step();
        check("flush_no_dispatch", 160'(bus.alu_valid_out), 160'(1'b0));

        // Illegal LW: one-cycle pulse and no allocation
        set_issue(TYPE_LW, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd8);
        step();
        check("illegal_pulse", 160'(bus.illegal_out), 160'(1'b1));
        set_idle();
        step();
        check("illegal_drop", 160'(bus.illegal_out), 160'(1'b0));
        step();
        check("illegal_no_alloc", 160'(bus.alu_valid_out), 160'(1'b0));

        // Freeze with rdy low: ready entry waits until rdy returns
        set_issue(TYPE_XORI, 1'b0, 4'd0, 32'd6, 1'b0, 4'd0, 32'd0, 32'd1, 4'd6);
        step();
        set_idle();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("freeze_hold", 160'(bus.alu_valid_out), 160'(1'b0));
        end
        rdy = 1'b1;
        step();
        check("freeze_release", 160'(bus.alu_dest_out), 160'(4'd6));

        // Reset while a dispatch is being presented
        set_issue(TYPE_ADDI, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd1, 4'd11);
        step();
        set_idle();
        step();
        check("pre_reset_valid", 160'(bus.alu_valid_out), 160'(1'b1));
        apply_reset();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            bus.iss_valid_in   = ($urandom_range(0, 9) < 6);
            bus.iss_type_in    = 6'($urandom_range(0, 37));
            bus.iss_qj_busy_in = $urandom_range(0, 1) == 1;
            bus.iss_qk_busy_in = $urandom_range(0, 1) == 1;
            bus.iss_qj_in      = 4'($urandom_range(0, 7));
            bus.iss_qk_in      = 4'($urandom_range(0, 7));
            bus.iss_vj_in      = $urandom;
            bus.iss_vk_in      = $urandom;
            bus.iss_imm_in     = $urandom;
            bus.iss_pc_in      = $urandom;
            bus.iss_dest_in    = 4'($urandom_range(0, 15));
            bus.cdb0_valid_in  = $urandom_range(0, 1) == 1;
            bus.cdb0_tag_in    = 4'($urandom_range(0, 7));
            bus.cdb0_val_in    = $urandom;
            bus.cdb1_valid_in  = $urandom_range(0, 1) == 1;
            bus.cdb1_tag_in    = 4'($urandom_range(0, 7));
            bus.cdb1_val_in    = (bus.cdb1_tag_in == bus.cdb0_tag_in) ? bus.cdb0_val_in : $urandom;
            rdy                = $urandom_range(0, 9) != 0;
            clr                = $urandom_range(0, 29) == 0;
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
